// File: rtl/sprite_pkg.sv
// sprite_pkg: shared sprite ROM geometry, transparent colour key and arbiter state encoding
package sprite_pkg;
    localparam int SPRITE_DIM = 16;
    localparam int SPRITE_ADDR_W = 4;
    localparam int COLOR_W = 8;
    localparam logic [COLOR_W-1:0] TRANSPARENT_COLOR = 8'b10111011;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} arb_state_e;
endpackage

// File: rtl/enemy_rom_arbiter_if.sv
// enemy_rom_arbiter_if: requester, sprite ROM and pixel-stream signals of the enemy ROM arbiter
interface enemy_rom_arbiter_if
    import sprite_pkg::*;
#(
    parameter int N_REQ = 4
);
    localparam int ID_W = $clog2(N_REQ);
    logic [N_REQ-1:0]               req;
    logic [SPRITE_ADDR_W*N_REQ-1:0] req_row;
    logic [N_REQ-1:0]               gnt;
    logic [SPRITE_ADDR_W-1:0]       rom_row;
    logic [SPRITE_ADDR_W-1:0]       rom_col;
    logic [COLOR_W-1:0]             rom_data;
    logic                           pix_valid;
    logic [ID_W-1:0]                pix_id;
    logic [SPRITE_ADDR_W-1:0]       pix_col;
    logic [COLOR_W-1:0]             pix_data;
    logic                           pix_opaque;
    logic                           done;
    modport master (
        output req, req_row, rom_data,
        input  gnt, rom_row, rom_col, pix_valid, pix_id, pix_col, pix_data, pix_opaque, done
    );
    modport slave (
        input  req, req_row, rom_data,
        output gnt, rom_row, rom_col, pix_valid, pix_id, pix_col, pix_data, pix_opaque, done
    );
endinterface

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: picks the first set request at or above ptr, wrapping past N_REQ-1
module rr_priority_picker #(
    parameter int N_REQ = 4,
    parameter int ID_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [ID_W-1:0]  idx,
    output logic             any
);
    logic [N_REQ-1:0] rot;

    function automatic int wrap(input int v);
        return (v >= N_REQ) ? v - N_REQ : v;
    endfunction

    // rot[k] is the request k places above ptr, so the lowest set bit wins
    always_comb begin
        rot = N_REQ'({req, req} >> ptr);
        idx = '0;
        any = |req;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (rot[k]) idx = ID_W'(wrap(int'(ptr) + k));
        onehot = any ? N_REQ'(1) << idx : '0;
    end
endmodule

// File: rtl/enemy_rom_arbiter.sv
// enemy_rom_arbiter: round-robin sharing of the enemy sprite ROM, one 16-pixel row burst per grant
module enemy_rom_arbiter
    import sprite_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int ID_W = $clog2(N_REQ)
) (
    input logic                clk,
    input logic                reset_n,
    enemy_rom_arbiter_if.slave bus
);
    localparam logic [SPRITE_ADDR_W-1:0] COL_LAST = SPRITE_ADDR_W'(SPRITE_DIM - 1);

    arb_state_e               state_q, state_d;
    logic [N_REQ-1:0]         gnt_q, gnt_d, win_oh;
    logic [SPRITE_ADDR_W-1:0] row_q, row_d, col_q, col_d, pix_col_q, pix_col_d;
    logic [ID_W-1:0]          id_q, id_d, ptr_q, ptr_d, win_idx;
    logic                     pix_valid_q, pix_valid_d, win_any;

    rr_priority_picker #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .onehot (win_oh),
        .idx    (win_idx),
        .any    (win_any)
    );

    always_comb begin
        state_d = state_q;
        gnt_d = gnt_q;
        row_d = row_q;
        col_d = col_q;
        id_d = id_q;
        ptr_d = ptr_q;
        pix_valid_d = state_q == ISSUE;
        pix_col_d = col_q;
        case (state_q)
            IDLE: if (win_any) begin
                state_d = ISSUE;
                gnt_d = win_oh;
                row_d = SPRITE_ADDR_W'(bus.req_row >> (SPRITE_ADDR_W * int'(win_idx)));
                col_d = '0;
                id_d = win_idx;
                ptr_d = (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + 1'b1;
            end
            ISSUE: begin
                state_d = (col_q == COL_LAST) ? DRAIN : ISSUE;
                col_d = (col_q == COL_LAST) ? col_q : col_q + 1'b1;
            end
            DRAIN: begin
                state_d = IDLE;
                gnt_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            gnt_q <= '0;
            row_q <= '0;
            col_q <= '0;
            id_q <= '0;
            ptr_q <= '0;
            pix_valid_q <= 1'b0;
            pix_col_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q <= gnt_d;
            row_q <= row_d;
            col_q <= col_d;
            id_q <= id_d;
            ptr_q <= ptr_d;
            pix_valid_q <= pix_valid_d;
            pix_col_q <= pix_col_d;
        end
    end

    // DRAIN is the cycle the last ROM word returns, so done rides with column 15
    assign bus.gnt = gnt_q;
    assign bus.rom_row = row_q;
    assign bus.rom_col = col_q;
    assign bus.pix_valid = pix_valid_q;
    assign bus.pix_id = id_q;
    assign bus.pix_col = pix_col_q;
    assign bus.pix_data = bus.rom_data;
    assign bus.pix_opaque = pix_valid_q && (bus.rom_data != TRANSPARENT_COLOR);
    assign bus.done = state_q == DRAIN;
endmodule

// File: tb/tb_enemy_rom_arbiter.sv
// tb_enemy_rom_arbiter: vector table, directed corner sequences and random traffic against a burst-level model
module tb_enemy_rom_arbiter;
    import sprite_pkg::*;
    localparam int N = 4;

    typedef struct {
        logic [N-1:0]   req;
        logic [4*N-1:0] rows;
        int             exp_id;
        int             exp_opq;
    } vec_t;

    logic clk, reset_n;
    int checks = 0, errors = 0, cyc = 0;
    int m_beat, m_owner, m_ptr, m_win;
    logic [3:0] m_row;
    vec_t tbl[7];
    int exp_ord[5];
    int ids[$], ts[$];
    int t0, t1, beats, opq, dn;
    logic [N-1:0] prev, r, m;

    enemy_rom_arbiter_if #(.N_REQ(N)) bus ();
    enemy_rom_arbiter #(.N_REQ(N)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] sprite(input logic [3:0] row, input logic [3:0] col);
        if (row == 0) return (col >= 4 && col <= 11) ? 8'hFC : 8'hBB;
        if (row == 5 && col >= 4 && col <= 6) return 8'h00;
        return {row, col};
    endfunction

    function automatic int pick(input logic [N-1:0] rq, input int p);
        for (int k = 0; k < N; k++)
            if (((rq >> ((p + k) % N)) & 1) != 0) return (p + k) % N;
        return -1;
    endfunction

    function automatic int oh2i(input logic [N-1:0] v);
        for (int k = 0; k < N; k++)
            if (((v >> k) & 1) != 0) return k;
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(posedge clk) bus.rom_data <= sprite(bus.rom_row, bus.rom_col);

    // Burst-level model: beat 0 is the grant cycle, beats 1..16 carry columns 0..15
    always_comb m_win = pick(bus.req, m_ptr);
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_beat <= -1;
            m_owner <= 0;
            m_ptr <= 0;
            m_row <= 0;
        end else if (m_beat < 0) begin
            if (m_win >= 0) begin
                m_beat <= 0;
                m_owner <= m_win;
                m_row <= 4'(bus.req_row >> (4 * m_win));
                m_ptr <= (m_win + 1) % N;
            end
        end else begin
            m_beat <= (m_beat == 16) ? -1 : m_beat + 1;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk("gnt", bus.gnt, (m_beat >= 0) ? (1 << m_owner) : 0);
            chk("done", bus.done, m_beat == 16);
            chk("pix_valid", bus.pix_valid, m_beat >= 1);
            if (m_beat >= 0) begin
                chk("rom_row", bus.rom_row, m_row);
                chk("rom_col", bus.rom_col, (m_beat > 15) ? 15 : m_beat);
            end
            if (m_beat >= 1) begin
                chk("pix_col", bus.pix_col, m_beat - 1);
                chk("pix_id", bus.pix_id, m_owner);
                chk("pix_data", bus.pix_data, sprite(m_row, 4'(m_beat - 1)));
                chk("pix_opaque", bus.pix_opaque, sprite(m_row, 4'(m_beat - 1)) != 8'b10111011);
            end else begin
                chk("pix_opaque_idle", bus.pix_opaque, 0);
            end
        end
    end

    task automatic chk_zero();
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_rom_row", bus.rom_row, 0);
        chk("rst_rom_col", bus.rom_col, 0);
        chk("rst_pix_valid", bus.pix_valid, 0);
        chk("rst_pix_id", bus.pix_id, 0);
        chk("rst_pix_col", bus.pix_col, 0);
        chk("rst_pix_opaque", bus.pix_opaque, 0);
        chk("rst_done", bus.done, 0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.gnt == 0) return;
        end
        chk("idle_timeout", 1, 0);
    endtask

    task automatic wait_gnt(input string nm, output int t);
        t = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.gnt != 0) begin
                t = cyc;
                return;
            end
        end
        chk(nm, 0, 1);
    endtask

    task automatic run_burst(input int drop_at, input logic [N-1:0] new_req,
                             output int nb, output int no, output int nd);
        nb = 0;
        no = 0;
        nd = 0;
        for (int i = 0; i < 30 && nd == 0; i++) begin
            @(negedge clk);
            nb += int'(bus.pix_valid);
            no += int'(bus.pix_opaque);
            nd = int'(bus.done);
            if (i + 1 == drop_at) bus.req = new_req;
        end
    endtask

    initial begin
        tbl[0] = '{4'b0001, 16'h0005, 0, 16};
        tbl[1] = '{4'b0001, 16'h0000, 0, 8};
        tbl[2] = '{4'b1100, 16'h3A00, 2, 16};
        tbl[3] = '{4'b0110, 16'h00B0, 1, 15};
        tbl[4] = '{4'b0110, 16'h0700, 2, 16};
        tbl[5] = '{4'b1001, 16'hF00C, 3, 16};
        tbl[6] = '{4'b1010, 16'h0050, 1, 16};
        exp_ord = '{0, 1, 2, 3, 0};
        bus.req = '0;
        bus.req_row = '0;
        reset_n = 1;
        #1 reset_n = 0;
        repeat (3) @(negedge clk);
        chk_zero();
        reset_n = 1;

        foreach (tbl[i]) begin
            bus.req = tbl[i].req;
            bus.req_row = tbl[i].rows;
            wait_gnt("tbl_gnt_timeout", t0);
            chk("tbl_gnt", bus.gnt, 1 << tbl[i].exp_id);
            bus.req = '0;
            run_burst(-1, '0, beats, opq, dn);
            chk("tbl_beats", beats, 16);
            chk("tbl_opaque", opq, tbl[i].exp_opq);
            chk("tbl_done", dn, 1);
            wait_idle();
        end

        reset_n = 0;
        @(negedge clk);
        reset_n = 1;
        bus.req = '1;
        prev = '0;
        for (int i = 0; i < 120 && ids.size() < 5; i++) begin
            @(negedge clk);
            bus.req_row = 16'($urandom);
            if (bus.gnt != 0 && prev == 0) begin
                ids.push_back(oh2i(bus.gnt));
                ts.push_back(cyc);
            end
            prev = bus.gnt;
        end
        bus.req = '0;
        chk("fair_cnt", ids.size(), 5);
        foreach (ids[k]) begin
            chk("fair_id", ids[k], exp_ord[k]);
            if (k > 0) chk("fair_gap", ts[k] - ts[k-1], 18);
        end
        wait_idle();

        bus.req = 4'b0100;
        wait_gnt("drop_gnt_timeout", t0);
        chk("drop_gnt", bus.gnt, 4'b0100);
        run_burst(5, 4'b0010, beats, opq, dn);
        chk("drop_beats", beats, 16);
        chk("drop_done", dn, 1);
        wait_gnt("drop_next_timeout", t1);
        chk("drop_next_gnt", bus.gnt, 4'b0010);
        chk("drop_next_time", t1 - t0, 18);
        bus.req = '0;
        run_burst(-1, '0, beats, opq, dn);
        wait_idle();

        bus.req = 4'b1000;
        bus.req_row = 16'h9000;
        wait_gnt("rst_gnt_timeout", t0);
        bus.req = '0;
        repeat (8) @(posedge clk);
        #2 reset_n = 0;
        #1 chk_zero();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_no_done", bus.done, 0);
        end
        reset_n = 1;
        bus.req = 4'b0001;
        wait_gnt("rst_regnt_timeout", t0);
        chk("rst_regnt", bus.gnt, 4'b0001);
        bus.req = '0;
        @(negedge clk);
        chk("rst_first_valid", bus.pix_valid, 1);
        chk("rst_first_col", bus.pix_col, 0);
        run_burst(-1, '0, beats, opq, dn);
        chk("rst_rest_beats", beats, 15);
        wait_idle();

        for (int i = 0; i < 900; i++) begin
            @(negedge clk);
            r = bus.req;
            for (int b = 0; b < N; b++) begin
                m = N'(1) << b;
                if ((r & bus.gnt & m) != 0) r = ($urandom_range(3) != 0) ? (r & ~m) : r;
                else if ((r & m) == 0 && $urandom_range(7) == 0) r = r | m;
            end
            bus.req = r;
            bus.req_row = 16'($urandom);
        end
        bus.req = '0;
        repeat (40) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/enemy_rom_arbiter.md
# enemy_rom_arbiter

Round-robin scheduler that shares one registered 16x16 enemy sprite ROM (4-bit row/col address in, 8-bit RRRGGGBB colour one cycle later) among `N_REQ` enemy instances. Each grant fetches one full 16-pixel sprite row as a burst and streams it, tagged with requester id and column, into the per-enemy line buffers of the pixel pipeline. Transparent pixels are flagged so downstream compositing does not decode colours itself.

## Interface
- `N_REQ`, default 4: number of requesters, legal 2..8.
- `ID_W`, default `$clog2(N_REQ)`: width of requester id. Derived; never overridden.
- `clk` in 1: system clock.
- `reset_n` in 1: reset, asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- `req` in `N_REQ`: level request per enemy; held until its `gnt` bit rises.
- `req_row` in `4*N_REQ`: sprite row for requester i in bits [4i+3:4i]; sampled only on the grant cycle.
- `gnt` out `N_REQ`: one-hot grant, high for the entire burst.
- `rom_row` out 4: row address to ROM (registered).
- `rom_col` out 4: column address to ROM (registered).
- `rom_data` in 8: ROM colour, valid one cycle after address.
- `pix_valid` out 1: `pix_*` carries a fetched pixel.
- `pix_id` out `ID_W`: requester owning the pixel.
- `pix_col` out 4: column of the pixel.
- `pix_data` out 8: `rom_data` passed through.
- `pix_opaque` out 1: 0 when `pix_data == 8'b10111011` (transparent key), else 1.
- `done` out 1: one-cycle pulse with the last pixel of a burst.

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE: if any `req` bit is set, pick a winner round-robin starting at `rr_ptr`, searching upward with wrap. Next cycle: ISSUE, `gnt` = winner one-hot, `rom_row` = latched `req_row` slice, `rom_col` = 0, `cur_id` = winner, `rr_ptr` = winner+1 mod `N_REQ`.
- ISSUE: `rom_col` increments each cycle 0..15. When `rom_col == 15`, go to DRAIN.
- DRAIN: one cycle for the final ROM return; `done` = 1; then IDLE with `gnt` = 0.
- Pixel stream: `pix_valid`/`pix_col` are `ISSUE`/`rom_col` delayed one cycle. `pix_id` = `cur_id`. `pix_data`/`pix_opaque` are combinational from `rom_data`, qualified by `pix_valid`. When `pix_valid` = 0, `pix_data` is don't-care and `pix_opaque` = 0.
- `req` changes during a burst are ignored. A requester that drops `req` mid-burst still receives its full 16 pixels.
- A requester still asserting `req` after its `done` is re-arbitrated normally. `rr_ptr` has already moved past it, so other pending requesters win first.
- `rr_ptr` wraps from `N_REQ-1` to 0. Column counter arithmetic is 4-bit; 15 is terminal and never wraps inside a burst.

## Timing
- Reset values: `gnt` = 0, `rom_row` = 0, `rom_col` = 0, `pix_valid` = 0, `pix_id` = 0, `pix_col` = 0, `pix_opaque` = 0, `done` = 0, state IDLE, `rr_ptr` = 0.
- Request to grant: `req` seen in IDLE at cycle T; `gnt`/ISSUE at T+1 with `rom_col` = 0. First `pix_valid` at T+2 (col 0). Last pixel (col 15) plus `done` at T+17. IDLE at T+18. Earliest next grant is T+19.
- Burst occupancy: 17 cycles with `gnt` high. Peak throughput: 16 pixels per 18 cycles.
- Reset asserted mid-burst: all outputs return to reset values immediately (asynchronously). No `done` is emitted and the partial burst is discarded. Requesters re-request after reset.
- `done` never coincides with a new `gnt` rising edge.

## Structure
- Shared package `sprite_pkg`:
  - `SPRITE_DIM` = 16
  - `SPRITE_ADDR_W` = 4
  - `COLOR_W` = 8
  - `TRANSPARENT_COLOR` = 8'b10111011
  - arbiter state enum (IDLE/ISSUE/DRAIN)
- Sub-module `rr_priority_picker`: combinational, `N_REQ`-wide request vector plus pointer in, one-hot winner plus index plus `any` out. Reusable by future bullet/explosion ROM arbiters.
- ROM is not instantiated inside; the top level wires `rom_row`/`rom_col`/`rom_data` to the enemy sprite ROM.

## Test plan
- Single request: `req` = 4'b0001, `req_row[3:0]` = 5, asserted at T → `gnt` = 0001 at T+1. Sixteen `pix_valid` beats T+2..T+17 with `pix_col` 0..15 and `pix_id` = 0. Cols 4-6 give `pix_data` = 8'h00, `pix_opaque` = 1. `done` at T+17.
- Transparency: request row 0 → cols 0-3 and 12-15 give `pix_opaque` = 0; cols 4-11 give `pix_data` = 8'b11111100 with `pix_opaque` = 1.
- Fairness: `req` = 4'b1111 held continuously → grant order 0,1,2,3,0, with each grant exactly 18 cycles after the previous one.
- Wrap and skip: `rr_ptr` = 3 with `req` = 4'b0110 → requester 1 granted, then requester 2.
- Mid-burst request drop: requester 2 drops `req` at burst cycle 5 → still 16 pixels and `done`. Concurrent `req[1]` rising during the burst is granted at T+19.
- Reset mid-burst: `reset_n` low at burst cycle 8 → all outputs 0 within the same cycle, no `done`. After release with `req` = 0001, a normal burst starts with `pix_col` = 0.
